// File: rtl/avalon_mm_master.sv
// Avalon-MM initiator for the CPU load/store path: one request at a time,
// lane-steered writes, lane-extracted and extended reads, optional stall watchdog.
module avalon_mm_master #(
    parameter int WAIT_TIMEOUT = 0,
    parameter int TIMEOUT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {IDLE, BUS, RDATA, DONE} state_t;

    localparam bit                   WD_EN        = (WAIT_TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(WAIT_TIMEOUT - 1);

    state_t               state;
    logic [1:0]           addr_lo;
    logic [1:0]           size_q;
    logic                 signed_q;
    logic [TIMEOUT_W-1:0] wait_cnt;

    logic                 req_bad;
    logic [3:0]           be_next;
    logic [31:0]          wd_next;
    logic [31:0]          byte_lane;
    logic [31:0]          half_lane;
    logic [31:0]          rdata_next;

    // Request decode: alignment/size legality and lane steering from the live cpu_* inputs.
    always_comb begin
        req_bad = 1'b0;
        be_next = 4'b0001 << cpu_addr[1:0];
        wd_next = {4{cpu_wdata[7:0]}};
        case (cpu_size)
            2'b01: begin
                req_bad = cpu_addr[0];
                be_next = cpu_addr[1] ? 4'b1100 : 4'b0011;
                wd_next = {2{cpu_wdata[15:0]}};
            end
            2'b10: begin
                req_bad = |cpu_addr[1:0];
                be_next = 4'b1111;
                wd_next = cpu_wdata;
            end
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end

    // Load result: pick the addressed lane, then sign- or zero-extend it.
    always_comb begin
        byte_lane  = readdata >> {addr_lo, 3'b000};
        half_lane  = readdata >> {addr_lo[1], 4'b0000};
        rdata_next = readdata;
        case (size_q)
            2'b00:   rdata_next = {{24{signed_q & byte_lane[7]}}, byte_lane[7:0]};
            2'b01:   rdata_next = {{16{signed_q & half_lane[15]}}, half_lane[15:0]};
            default: rdata_next = readdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_lo    <= 2'b00;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            wait_cnt   <= '0;
            cpu_busy   <= 1'b0;
            cpu_done   <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= 32'h0;
            address    <= 32'h0;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'b0000;
            writedata  <= 32'h0;
        end else begin
            cpu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_lo  <= cpu_addr[1:0];
                        size_q   <= cpu_size;
                        signed_q <= cpu_signed;
                        wait_cnt <= '0;
                        cpu_busy <= 1'b1;
                        if (req_bad) begin
                            cpu_err  <= 1'b1;
                            cpu_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cpu_err    <= 1'b0;
                            address    <= {cpu_addr[31:2], 2'b00};
                            byteenable <= be_next;
                            writedata  <= wd_next;
                            write      <= cpu_we;
                            read       <= ~cpu_we;
                            state      <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        read     <= 1'b0;
                        write    <= 1'b0;
                        wait_cnt <= '0;
                        if (write) begin
                            cpu_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= RDATA;
                        end
                    end else if (WD_EN && wait_cnt == TIMEOUT_LAST) begin
                        // Responder stalled too long: abandon the cycle and report an error.
                        read     <= 1'b0;
                        write    <= 1'b0;
                        wait_cnt <= '0;
                        cpu_err  <= 1'b1;
                        cpu_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RDATA: begin
                    cpu_rdata <= rdata_next;
                    cpu_done  <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    cpu_busy <= 1'b0;
                    cpu_err  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/avalon_mm_master.md
Name: avalon_mm_master

Overview:
- CPU-side bus interface unit that drives the Avalon memory-mapped initiator end of the data/instruction bus, the counterpart of the RAM responder used in the testbenches.
- Accepts one load/store request at a time: byte, halfword or word.
- Generates a word-aligned address, byteenable and lane-replicated writedata, and honours waitrequest.
- Returns lane-extracted, sign- or zero-extended read data with a one-cycle done pulse.

Parameters:
- WAIT_TIMEOUT, 0: max consecutive cycles with waitrequest high before abort; 0 disables the watchdog.
- TIMEOUT_W, 16: width of the wait counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- cpu_req  input  1  request strobe, sampled only in IDLE
- cpu_we  input  1  1=store, 0=load
- cpu_addr  input  32  byte address
- cpu_size  input  2  00 byte, 01 half, 10 word; 11 is illegal
- cpu_signed  input  1  sign-extend loads when 1
- cpu_wdata  input  32  store data, right-justified
- cpu_busy  output  1  high from capture until the done pulse, inclusive
- cpu_done  output  1  one-cycle completion pulse
- cpu_err  output  1  valid with cpu_done: misaligned, illegal size or timeout
- cpu_rdata  output  32  load result; held until the next load completes
- address  output  32  Avalon address {addr[31:2],2'b00}
- read  output  1  Avalon read
- write  output  1  Avalon write
- byteenable  output  4  Avalon byte lanes
- writedata  output  32  Avalon write data
- waitrequest  input  1  responder stall
- readdata  input  32  responder data

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 (read, write, byteenable, address, writedata, cpu_busy, cpu_done, cpu_err, cpu_rdata); wait counter 0. Reset mid-transaction abandons it with no done pulse.
- States: IDLE, BUS, RDATA, DONE.
- IDLE: cpu_req=1 at edge E0 captures all cpu_* inputs.
  - Legal request: go to BUS.
  - Misaligned (word with addr[1:0]!=0, half with addr[0]!=0) or size 11: go to DONE with err=1; no bus cycle.
- Lane generation:
  - Byte: byteenable = 4'b0001 << addr[1:0]; writedata = {4{wdata[7:0]}}.
  - Half: byteenable = addr[1] ? 1100 : 0011; writedata = {2{wdata[15:0]}}.
  - Word: byteenable = 1111; writedata = wdata.
- BUS: read or write held high; address, byteenable and writedata held stable.
  - Acceptance is a rising edge with waitrequest=0.
  - Write accepted: go to DONE and drop write.
  - Read accepted: go to RDATA and drop read.
- RDATA: readdata is sampled on the next edge (fixed read latency 1), then go to DONE.
  - Lane select: shift right by 8*addr[1:0] for byte, 16*addr[1] for half.
  - Extend: sign-extend if cpu_signed, else zero-extend; word loads are unmodified.
  - Result is loaded into cpu_rdata.
- DONE: cpu_done=1 for exactly one cycle, cpu_err as determined, then IDLE.
  - cpu_busy drops in the same edge that ends the done pulse.
  - A new cpu_req is accepted only in IDLE, so the minimum gap is one cycle.
  - cpu_req while busy is ignored, not queued.
- Latency with waitrequest low throughout, request at E0:
  - Write: bus active E0–E1, done high E1–E2.
  - Read: bus active E0–E1, readdata sampled E2, done high E2–E3.
  - Each waitrequest-high cycle adds one cycle.
- Watchdog: counter increments each BUS cycle with waitrequest=1 and clears on acceptance.
  - If WAIT_TIMEOUT!=0 and count reaches WAIT_TIMEOUT, drop read/write and go to DONE with err=1.
  - cpu_rdata is left unchanged.
- On error, cpu_rdata is unchanged. read and write are never high simultaneously.
- Address mapping is not performed here; the full 32-bit address is passed through, word-aligned.

Test Plan:
- Word store, cpu_addr=0x80000004, wdata=0xDEADBEEF, waitrequest=0.
  → address=0x80000004, byteenable=1111, write high one cycle, done at E1–E2, err=0.
- Signed byte load at 0xBFC00003, RAM word 0x80112233, waitrequest=0.
  → byteenable=1000, cpu_rdata=0xFFFFFF80; same load unsigned → 0x00000080; done at E2–E3.
- Half store, addr=0x00000102, wdata=0x0000ABCD, waitrequest high 3 cycles.
  → address=0x00000100, byteenable=1100, writedata=0xABCDABCD; outputs stable while stalled; done on cycle 4.
- Misaligned word load at 0x00000002.
  → no read asserted; cpu_done=1 and cpu_err=1 in the cycle after capture; cpu_rdata unchanged.
- WAIT_TIMEOUT=4, read with waitrequest stuck high.
  → read drops after 4 stalled cycles; done+err pulse; a subsequent request proceeds normally.
- Reset asserted mid-BUS during a read.
  → read, cpu_busy and cpu_done go to 0 immediately with no done pulse; a new request after reset is accepted in IDLE.
